// File: rtl/buzz_arbiter.sv
// rtl/buzz_arbiter.sv - quiz-round buzzer arbiter with rotating priority, answer countdown and scoring
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   player_num   configured player count (2..4, clamped outside that range)
//   start        pulse, arms a round
//   buzz         buzzer level per player, bit i = player i
//   judge_right  host pulse, current answer correct
//   judge_wrong  host pulse, current answer wrong
//   tick         time-base enable for the answer countdown
//   state        00 IDLE, 01 ARMED, 10 ANSWER, 11 DONE
//   winner       index of the granted player (holds after ANSWER)
//   winner_valid high only while in ANSWER
//   time_left    remaining answer ticks
//   lockout      players barred for the rest of the round
//   scores       4-bit saturating score per player, player i on [4i+3:4i]
//   foul         false-start flags
//
// Optional feature macro: FALSE_START_EN
//   defined   - buzzing in IDLE/DONE marks a foul; the fouling players are locked
//               out of the next round, and a round where everyone fouled ends at once
//   undefined - foul is tied to 0 and start always clears lockout

module buzz_arbiter #(
    parameter int ANSWER_TIME = 9,
    parameter int SCORE_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  player_num,
    input  logic        start,
    input  logic [3:0]  buzz,
    input  logic        judge_right,
    input  logic        judge_wrong,
    input  logic        tick,
    output logic [1:0]  state,
    output logic [1:0]  winner,
    output logic        winner_valid,
    output logic [3:0]  time_left,
    output logic [3:0]  lockout,
    output logic [15:0] scores,
    output logic [3:0]  foul
);

    localparam logic [3:0] L_ANSWER_TIME = 4'(ANSWER_TIME);
    localparam logic [3:0] L_SCORE_MAX   = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_ANSWER = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t      r_state;
    logic [1:0]  r_winner;
    logic [1:0]  r_last_winner;
    logic        r_winner_valid;
    logic [3:0]  r_time_left;
    logic [3:0]  r_lockout;
    logic [15:0] r_scores;
    logic [3:0]  r_foul;

    logic [3:0]  w_active_mask;
    logic [3:0]  w_eligible;
    logic        w_grant_valid;
    logic [1:0]  w_grant_idx;
    logic        w_judge_right;
    logic        w_judge_wrong;
    logic        w_timeout;
    logic [3:0]  w_lock_after_miss;
    logic        w_any_left;
    logic [3:0]  w_score_cur;
    logic [3:0]  w_score_next;
    logic [3:0]  w_foul_next;
    logic [3:0]  w_arm_lock;
    logic        w_arm_ok;

    // Counts below 2 behave as 2, counts above 4 behave as 4.
    always_comb begin
        w_active_mask = 4'b1111;
        case (player_num)
            3'd0, 3'd1, 3'd2: w_active_mask = 4'b0011;
            3'd3:             w_active_mask = 4'b0111;
            default:          w_active_mask = 4'b1111;
        endcase
    end

    assign w_eligible = buzz & w_active_mask & ~r_lockout;

    // Rotating priority: first eligible player after the last winner, wrapping
    // modulo 4. Inactive players are already masked out of w_eligible.
    always_comb begin : grant_search
        logic [1:0] v_idx;
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        v_idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last_winner + 2'(k);
            if (!w_grant_valid && w_eligible[v_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = v_idx;
            end
        end
    end

    // Conflicting judgements cancel each other.
    assign w_judge_right     = judge_right & ~judge_wrong;
    assign w_judge_wrong     = judge_wrong & ~judge_right;
    assign w_timeout         = tick & (r_time_left == 4'd1);
    assign w_lock_after_miss = r_lockout | (4'b0001 << r_winner);
    assign w_any_left        = |(w_active_mask & ~w_lock_after_miss);

    assign w_score_cur  = r_scores[{r_winner, 2'b00} +: 4];
    assign w_score_next = (w_score_cur >= L_SCORE_MAX) ? w_score_cur : w_score_cur + 4'd1;

`ifdef FALSE_START_EN
    // A buzz on the very cycle start is accepted still counts as a false start.
    assign w_foul_next = r_foul | (buzz & w_active_mask);
    assign w_arm_lock  = w_foul_next;
    assign w_arm_ok    = |(w_active_mask & ~w_foul_next);
`else
    assign w_foul_next = 4'b0000;
    assign w_arm_lock  = 4'b0000;
    assign w_arm_ok    = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_winner       <= 2'd0;
            r_last_winner  <= 2'd3;
            r_winner_valid <= 1'b0;
            r_time_left    <= 4'd0;
            r_lockout      <= 4'b0000;
            r_scores       <= 16'h0000;
            r_foul         <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_foul <= w_foul_next;
                    if (start) begin
                        r_lockout <= w_arm_lock;
                        r_foul    <= 4'b0000;
                        r_state   <= w_arm_ok ? S_ARMED : S_DONE;
                    end
                end
                S_ARMED: begin
                    if (w_grant_valid) begin
                        r_winner       <= w_grant_idx;
                        r_last_winner  <= w_grant_idx;
                        r_winner_valid <= 1'b1;
                        r_time_left    <= L_ANSWER_TIME;
                        r_state        <= S_ANSWER;
                    end
                end
                S_ANSWER: begin
                    if (w_judge_right) begin
                        r_scores[{r_winner, 2'b00} +: 4] <= w_score_next;
                        r_winner_valid <= 1'b0;
                        r_state        <= S_DONE;
                    end else if (w_judge_wrong || w_timeout) begin
                        // A timeout consumes its tick, so the countdown ends at 0.
                        if (!w_judge_wrong) begin
                            r_time_left <= 4'd0;
                        end
                        r_lockout      <= w_lock_after_miss;
                        r_winner_valid <= 1'b0;
                        r_state        <= w_any_left ? S_ARMED : S_DONE;
                    end else if (tick && (r_time_left != 4'd0)) begin
                        r_time_left <= r_time_left - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state        = r_state;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign time_left    = r_time_left;
    assign lockout      = r_lockout;
    assign scores       = r_scores;
    assign foul         = r_foul;

endmodule

// File: tb/tb_buzz_arbiter.sv
// tb/tb_buzz_arbiter.sv - self-checking bench for buzz_arbiter: directed scenarios plus randomized run against a round-level model

module tb_buzz_arbiter;

    localparam int ANSWER_TIME = 9;
    localparam int SCORE_MAX   = 15;

    logic        clk;
    logic        rst;
    logic [2:0]  player_num;
    logic        start;
    logic [3:0]  buzz;
    logic        judge_right;
    logic        judge_wrong;
    logic        tick;
    logic [1:0]  state;
    logic [1:0]  winner;
    logic        winner_valid;
    logic [3:0]  time_left;
    logic [3:0]  lockout;
    logic [15:0] scores;
    logic [3:0]  foul;

    int tests;
    int fails;

    buzz_arbiter #(.ANSWER_TIME(ANSWER_TIME), .SCORE_MAX(SCORE_MAX)) dut (
        .clk(clk), .rst(rst), .player_num(player_num), .start(start), .buzz(buzz),
        .judge_right(judge_right), .judge_wrong(judge_wrong), .tick(tick),
        .state(state), .winner(winner), .winner_valid(winner_valid),
        .time_left(time_left), .lockout(lockout), .scores(scores), .foul(foul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: round phase as a small integer, players as arrays.
    int       m_phase;   // 0 idle, 1 armed, 2 answering, 3 done
    int       m_winner;
    int       m_valid;
    int       m_time;
    int       m_last;
    bit [3:0] m_lock;
    bit [3:0] m_foul;
    int       m_score[4];

    function automatic void model_reset();
        m_phase = 0; m_winner = 0; m_valid = 0; m_time = 0; m_last = 3;
        m_lock = 4'b0; m_foul = 4'b0;
        for (int i = 0; i < 4; i++) m_score[i] = 0;
    endfunction

    function automatic void model_step(input bit [3:0] b, input bit s, input bit jr,
                                       input bit jw, input bit tk, input int pn);
        int  n;
        int  free;
        int  p;
        bit  found;
        bit  right_only;
        bit  wrong_only;
        n = (pn < 2) ? 2 : ((pn > 4) ? 4 : pn);
        right_only = jr && !jw;
        wrong_only = jw && !jr;
        if (m_phase == 0 || m_phase == 3) begin
`ifdef FALSE_START_EN
            for (int i = 0; i < n; i++) if (b[i]) m_foul[i] = 1'b1;
`endif
            if (s) begin
                m_lock = m_foul;
                m_foul = 4'b0;
                free = 0;
                for (int i = 0; i < n; i++) if (!m_lock[i]) free++;
                m_phase = (free > 0) ? 1 : 3;
            end
        end else if (m_phase == 1) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                p = (m_last + k) % 4;
                if (!found && p < n && b[p] && !m_lock[p]) begin
                    found = 1'b1;
                    m_winner = p; m_last = p; m_valid = 1; m_time = ANSWER_TIME; m_phase = 2;
                end
            end
        end else begin
            if (right_only) begin
                if (m_score[m_winner] < SCORE_MAX) m_score[m_winner]++;
                m_valid = 0; m_phase = 3;
            end else if (wrong_only || (tk && m_time == 1)) begin
                if (!wrong_only) m_time = 0;
                m_lock[m_winner] = 1'b1;
                free = 0;
                for (int i = 0; i < n; i++) if (!m_lock[i]) free++;
                m_valid = 0;
                m_phase = (free > 0) ? 1 : 3;
            end else if (tk && m_time > 0) begin
                m_time--;
            end
        end
    endfunction

    task automatic cycle(input logic [3:0] b, input logic s, input logic jr,
                         input logic jw, input logic tk);
        buzz = b; start = s; judge_right = jr; judge_wrong = jw; tick = tk;
        @(posedge clk);
        model_step(b, s, jr, jw, tk, int'(player_num));
        #1;
        buzz = 4'b0; start = 1'b0; judge_right = 1'b0; judge_wrong = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        buzz = 4'b0; start = 1'b0; judge_right = 1'b0; judge_wrong = 1'b0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (state !== 2'b00) begin fails++; $display("FAIL reset_state actual=%0d required=0", state); end
        tests++;
        if ({winner, winner_valid, time_left, lockout, scores, foul} !== 31'd0) begin
            fails++;
            $display("FAIL reset_outputs actual w=%0d v=%0d t=%0d l=%b s=%h f=%b required all zero",
                     winner, winner_valid, time_left, lockout, scores, foul);
        end
    endtask

    task automatic test_first_grant();
        logic [3:0] first_buzz;
`ifdef FALSE_START_EN
        first_buzz = 4'b0000;
`else
        first_buzz = 4'b0110;
`endif
        player_num = 3'b100;
        cycle(first_buzz, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (state !== 2'b01 || winner_valid !== 1'b0) begin
            fails++; $display("FAIL arm_state actual=%0d/%0d required=1/0", state, winner_valid);
        end
        cycle(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (winner !== 2'd1 || winner_valid !== 1'b1 || time_left !== 4'd9) begin
            fails++; $display("FAIL first_grant actual w=%0d v=%0d t=%0d required w=1 v=1 t=9",
                              winner, winner_valid, time_left);
        end
        cycle(4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (scores[7:4] !== 4'd1 || state !== 2'b11 || winner_valid !== 1'b0 || winner !== 2'd1) begin
            fails++; $display("FAIL judge_right actual s1=%0d st=%0d v=%0d w=%0d required s1=1 st=3 v=0 w=1",
                              scores[7:4], state, winner_valid, winner);
        end
    endtask

    task automatic test_rotation();
        cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (winner !== 2'd2) begin fails++; $display("FAIL rotate_to_2 actual=%0d required=2", winner); end
        cycle(4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (winner !== 2'd0) begin fails++; $display("FAIL rotate_wrap_0 actual=%0d required=0", winner); end
        cycle(4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_inactive_players();
        player_num = 3'b010;
        cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (state !== 2'b01 || winner_valid !== 1'b0) begin
            fails++; $display("FAIL inactive_buzz actual st=%0d v=%0d required st=1 v=0", state, winner_valid);
        end
    endtask

    task automatic test_timeout_lockout();
        cycle(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (winner !== 2'd0 || winner_valid !== 1'b1) begin
            fails++; $display("FAIL grant_p0 actual w=%0d v=%0d required w=0 v=1", winner, winner_valid);
        end
        repeat (8) cycle(4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (time_left !== 4'd1 || state !== 2'b10) begin
            fails++; $display("FAIL countdown actual t=%0d st=%0d required t=1 st=2", time_left, state);
        end
        cycle(4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (lockout !== 4'b0001 || state !== 2'b01 || winner_valid !== 1'b0) begin
            fails++; $display("FAIL timeout actual l=%b st=%0d v=%0d required l=0001 st=1 v=0",
                              lockout, state, winner_valid);
        end
        cycle(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (winner !== 2'd1) begin fails++; $display("FAIL grant_after_lock actual=%0d required=1", winner); end
        cycle(4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (lockout !== 4'b0011 || state !== 2'b11) begin
            fails++; $display("FAIL all_locked actual l=%b st=%0d required l=0011 st=3", lockout, state);
        end
    endtask

    task automatic test_saturation_and_reset();
        player_num = 3'b100;
        repeat (16) begin
            cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle(4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tests++;
        if (scores !== 16'h0F11) begin
            fails++; $display("FAIL score_saturate actual=%h required=0f11", scores);
        end
        cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        tests++;
        if ({state, winner, winner_valid, time_left, lockout, scores, foul} !== 33'd0) begin
            fails++; $display("FAIL async_reset actual st=%0d w=%0d v=%0d t=%0d l=%b s=%h f=%b required all zero",
                              state, winner, winner_valid, time_left, lockout, scores, foul);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

`ifdef FALSE_START_EN
    task automatic test_false_start();
        player_num = 3'b100;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (foul !== 4'b0001) begin fails++; $display("FAIL foul_set actual=%b required=0001", foul); end
        cycle(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (foul !== 4'b0000 || lockout !== 4'b0001 || state !== 2'b01) begin
            fails++; $display("FAIL foul_lock actual f=%b l=%b st=%0d required f=0000 l=0001 st=1",
                              foul, lockout, state);
        end
        cycle(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (state !== 2'b01 || winner_valid !== 1'b0) begin
            fails++; $display("FAIL fouled_buzz actual st=%0d v=%0d required st=1 v=0", state, winner_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0]  b;
        logic [15:0] exp_scores;
        do_reset();
        player_num = 3'b100;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) player_num = 3'($urandom_range(0, 7));
            b = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cycle(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            exp_scores = {m_score[3][3:0], m_score[2][3:0], m_score[1][3:0], m_score[0][3:0]};
            tests++;
            if (state !== 2'(m_phase)) begin
                fails++; $display("FAIL rnd_state cyc=%0d actual=%0d required=%0d", c, state, m_phase);
            end
            tests++;
            if (winner !== 2'(m_winner) || winner_valid !== 1'(m_valid)) begin
                fails++; $display("FAIL rnd_winner cyc=%0d actual=%0d/%0d required=%0d/%0d",
                                  c, winner, winner_valid, m_winner, m_valid);
            end
            tests++;
            if (time_left !== 4'(m_time)) begin
                fails++; $display("FAIL rnd_time cyc=%0d actual=%0d required=%0d", c, time_left, m_time);
            end
            tests++;
            if (lockout !== m_lock || foul !== m_foul) begin
                fails++; $display("FAIL rnd_lock cyc=%0d actual=%b/%b required=%b/%b",
                                  c, lockout, foul, m_lock, m_foul);
            end
            tests++;
            if (scores !== exp_scores) begin
                fails++; $display("FAIL rnd_scores cyc=%0d actual=%h required=%h", c, scores, exp_scores);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        player_num = 3'b100;
        buzz = 4'b0; start = 1'b0; judge_right = 1'b0; judge_wrong = 1'b0; tick = 1'b0;
        model_reset();
        test_reset();
        test_first_grant();
        test_rotation();
        test_inactive_players();
        test_timeout_lockout();
        test_saturation_and_reset();
`ifdef FALSE_START_EN
        test_false_start();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
